// File: rtl/snax_mac_stream_ctrl.sv
// rtl/snax_mac_stream_ctrl.sv - job controller that launches four MAC streams and tracks d-stream completion
module snax_mac_stream_ctrl #(
    parameter int LEN_W  = 16,
    parameter int ADDR_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [LEN_W-1:0]      len_i,
    input  logic [4*ADDR_W-1:0]   base_i,
    input  logic [3:0]            ready_start_i,
    input  logic [3:0]            strm_done_i,
    input  logic                  d_hs_i,
    output logic [3:0]            req_start_o,
    output logic [4*ADDR_W-1:0]   addr_o,
    output logic [LEN_W-1:0]      trans_size_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [LEN_W-1:0]      cnt_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, RUN, DONE} state_t;

    state_t             state;
    logic [3:0]         sticky;
    logic [LEN_W-1:0]   cnt_n;
    logic [3:0]         sticky_n;
    logic               fire;
    logic               overrun;
    logic               active;

    assign active = rst_ni && !clear_i;
    // All four streams launch together or not at all.
    assign fire   = (state == ISSUE) && (ready_start_i == 4'b1111);

    always_comb begin
        cnt_n    = cnt_o;
        sticky_n = sticky;
        overrun  = 1'b0;
        if (state == RUN) begin
            sticky_n = sticky | strm_done_i;
            if (d_hs_i) begin
                if (cnt_o < trans_size_o) begin
                    cnt_n = cnt_o + 1'b1;
                end else begin
                    overrun = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state        <= IDLE;
            cnt_o        <= '0;
            trans_size_o <= '0;
            addr_o       <= '0;
            sticky       <= '0;
            err_o        <= 1'b0;
        end else begin
            if ((start_i && state != IDLE) || overrun) begin
                err_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            addr_o       <= base_i;
                            trans_size_o <= len_i;
                            cnt_o        <= '0;
                            sticky       <= '0;
                            state        <= ISSUE;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    if (fire) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    cnt_o  <= cnt_n;
                    sticky <= sticky_n;
                    // Completion uses this cycle's events so the last handshake/done is not missed.
                    if (cnt_n == trans_size_o && sticky_n == 4'b1111) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign req_start_o = {4{fire && active}};
    assign busy_o      = (state != IDLE) && active;
    assign done_o      = (state == DONE) && active;

endmodule

// File: tb/tb_snax_mac_stream_ctrl.sv
// tb/tb_snax_mac_stream_ctrl.sv - directed self-checking bench for snax_mac_stream_ctrl
module tb_snax_mac_stream_ctrl;

    localparam int LEN_W  = 16;
    localparam int ADDR_W = 32;

    logic                clk;
    logic                rst_ni;
    logic                clear_i;
    logic                start_i;
    logic [LEN_W-1:0]    len_i;
    logic [4*ADDR_W-1:0] base_i;
    logic [3:0]          ready_start_i;
    logic [3:0]          strm_done_i;
    logic                d_hs_i;
    logic [3:0]          req_start_o;
    logic [4*ADDR_W-1:0] addr_o;
    logic [LEN_W-1:0]    trans_size_o;
    logic                busy_o;
    logic                done_o;
    logic [LEN_W-1:0]    cnt_o;
    logic                err_o;

    int checks;
    int failures;
    int done_cnt;
    int req_cnt;
    int d0;
    int r0;

    localparam logic [4*ADDR_W-1:0] B1 = 128'h0000_0400_0000_0300_0000_0200_0000_0100;
    localparam logic [4*ADDR_W-1:0] B2 = 128'hDEAD_0004_BEEF_0003_CAFE_0002_F00D_0001;
    localparam logic [4*ADDR_W-1:0] B3 = 128'h1111_1111_2222_2222_3333_3333_4444_4444;
    localparam logic [4*ADDR_W-1:0] B4 = 128'h8000_0000_0800_0000_0080_0000_0008_0000;

    snax_mac_stream_ctrl #(.LEN_W(LEN_W), .ADDR_W(ADDR_W)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .start_i       (start_i),
        .len_i         (len_i),
        .base_i        (base_i),
        .ready_start_i (ready_start_i),
        .strm_done_i   (strm_done_i),
        .d_hs_i        (d_hs_i),
        .req_start_o   (req_start_o),
        .addr_o        (addr_o),
        .trans_size_o  (trans_size_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .cnt_o         (cnt_o),
        .err_o         (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done_o) done_cnt <= done_cnt + 1;
        if (req_start_o != 4'b0000) req_cnt <= req_cnt + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0; failures = 0; done_cnt = 0; req_cnt = 0;
        rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; len_i = '0; base_i = '0;
        ready_start_i = 4'hF; strm_done_i = 4'h0; d_hs_i = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_req", req_start_o, 0);
        chk("rst_cnt", cnt_o, 0);
        chk("rst_size", trans_size_o, 0);
        chk("rst_addr", addr_o, 0);
        chk("rst_err", err_o, 0);
        @(negedge clk); rst_ni = 1'b1;

        // nominal job, len 8
        d0 = done_cnt;
        @(negedge clk); start_i = 1'b1; len_i = 16'd8; base_i = B1; #1;
        chk("s1_idle_busy", busy_o, 0);
        @(negedge clk); start_i = 1'b0; #1;
        chk("s1_req_fire", req_start_o, 4'hF);
        chk("s1_addr", addr_o, B1);
        chk("s1_size", trans_size_o, 8);
        chk("s1_cnt0", cnt_o, 0);
        chk("s1_busy", busy_o, 1);
        @(negedge clk); #1;
        chk("s1_req_once", req_start_o, 4'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); d_hs_i = 1'b1;
        end
        @(negedge clk); d_hs_i = 1'b0; strm_done_i = 4'hF; #1;
        chk("s1_cnt8", cnt_o, 8);
        chk("s1_no_early_done", done_o, 0);
        @(negedge clk); strm_done_i = 4'h0; #1;
        chk("s1_done", done_o, 1);
        chk("s1_busy_in_done", busy_o, 1);
        @(negedge clk); #1;
        chk("s1_done_pulse", done_o, 0);
        chk("s1_idle", busy_o, 0);
        chk("s1_done_count", done_cnt - d0, 1);
        chk("s1_err", err_o, 0);

        // stalled start, then staggered stream completions
        r0 = req_cnt;
        @(negedge clk); start_i = 1'b1; len_i = 16'd3; base_i = B2; ready_start_i = 4'b0111;
        @(negedge clk); start_i = 1'b0; #1;
        chk("s2_stall_req", req_start_o, 0);
        chk("s2_busy", busy_o, 1);
        chk("s2_addr", addr_o, B2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("s2_stall_req", req_start_o, 0);
        end
        @(negedge clk); ready_start_i = 4'hF; #1;
        chk("s2_req_fire", req_start_o, 4'hF);
        @(negedge clk); #1;
        chk("s2_req_once", req_start_o, 0);
        @(negedge clk); d_hs_i = 1'b1; strm_done_i = 4'b0011;
        @(negedge clk); strm_done_i = 4'b0100;
        @(negedge clk); strm_done_i = 4'b0000;
        @(negedge clk); d_hs_i = 1'b0; strm_done_i = 4'b1000; #1;
        chk("s2_cnt3", cnt_o, 3);
        chk("s2_wait_sticky", done_o, 0);
        chk("s2_wait_busy", busy_o, 1);
        @(negedge clk); strm_done_i = 4'b0000; #1;
        chk("s2_done", done_o, 1);
        @(negedge clk); #1;
        chk("s2_idle", busy_o, 0);
        chk("s2_req_count", req_cnt - r0, 1);

        // zero-length job
        r0 = req_cnt;
        @(negedge clk); start_i = 1'b1; len_i = 16'd0; base_i = B3; #1;
        chk("s3_idle", busy_o, 0);
        @(negedge clk); start_i = 1'b0; #1;
        chk("s3_done", done_o, 1);
        chk("s3_req", req_start_o, 0);
        chk("s3_addr_kept", addr_o, B2);
        chk("s3_size_kept", trans_size_o, 3);
        @(negedge clk); #1;
        chk("s3_done_pulse", done_o, 0);
        chk("s3_idle_after", busy_o, 0);
        chk("s3_no_req", req_cnt - r0, 0);

        // overrun and ignored restart
        @(negedge clk); start_i = 1'b1; len_i = 16'd2; base_i = B4;
        @(negedge clk); start_i = 1'b0;
        @(negedge clk); d_hs_i = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        chk("s4_cnt2", cnt_o, 2);
        chk("s4_no_err_yet", err_o, 0);
        @(negedge clk); d_hs_i = 1'b0; #1;
        chk("s4_sat", cnt_o, 2);
        chk("s4_err", err_o, 1);
        chk("s4_busy", busy_o, 1);
        @(negedge clk); start_i = 1'b1; len_i = 16'd5; base_i = B1;
        @(negedge clk); start_i = 1'b0; strm_done_i = 4'hF; #1;
        chk("s4_size_kept", trans_size_o, 2);
        chk("s4_addr_kept", addr_o, B4);
        chk("s4_err_sticky", err_o, 1);
        @(negedge clk); strm_done_i = 4'h0; #1;
        chk("s4_done", done_o, 1);
        @(negedge clk); #1;
        chk("s4_idle", busy_o, 0);
        chk("s4_err_kept", err_o, 1);
        @(negedge clk); clear_i = 1'b1; start_i = 1'b1; len_i = 16'd4; base_i = B1;
        @(negedge clk); clear_i = 1'b0; start_i = 1'b0; #1;
        chk("s4_clr_err", err_o, 0);
        chk("s4_clr_busy", busy_o, 0);
        chk("s4_clr_size", trans_size_o, 0);
        chk("s4_clr_addr", addr_o, 0);

        // clear mid-run
        @(negedge clk); start_i = 1'b1; len_i = 16'd8; base_i = B2;
        @(negedge clk); start_i = 1'b0;
        @(negedge clk); d_hs_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); #1;
        chk("s5_cnt3", cnt_o, 3);
        d0 = done_cnt;
        clear_i = 1'b1; #1;
        chk("s5_clr_busy_now", busy_o, 0);
        @(negedge clk); clear_i = 1'b0; d_hs_i = 1'b0; #1;
        chk("s5_busy", busy_o, 0);
        chk("s5_cnt", cnt_o, 0);
        chk("s5_size", trans_size_o, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("s5_no_done", done_cnt - d0, 0);
        chk("s5_still_idle", busy_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
